// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Time-division demultiplexer, the receive end of the mux-based channel
// combiner. A serial stream of WIDTH-bit words arrives one word per slot, in
// a repeating frame of CHANNELS slots. The sync flag marks slot 0 and is used
// to find and keep frame alignment. Words of a frame are collected in staging
// registers and, once the last slot arrives, the whole frame is published on
// dataout in a single edge, so downstream logic always sees a coherent
// snapshot of one frame.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   datain       incoming channel word
//   valid_in     datain/sync are meaningful this cycle
//   sync         current word belongs to slot 0 (ignored when valid_in=0)
//   dataout      last complete frame, channel k at [k*WIDTH +: WIDTH]
//   frame_valid  one-cycle pulse when dataout is updated
//   locked       high while the block is frame-aligned
//   slot         slot index the next accepted word will take
//   sync_err     one-cycle pulse when sync shows up at a slot other than 0
// ---------------------------------------------------------------------------
module tdm_demux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int SLOTW   = $clog2(CHANNELS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH-1:0]            datain,
   input  logic                        valid_in,
   input  logic                        sync,
   output logic [CHANNELS*WIDTH-1:0]   dataout,
   output logic                        frame_valid,
   output logic                        locked,
   output logic [SLOTW-1:0]            slot,
   output logic                        sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [SLOTW-1:0] LAST_SLOT  = SLOTW'(CHANNELS - 1);
   localparam logic [SLOTW-1:0] FIRST_NEXT = SLOTW'(1);

   state_t                      state_q;
   state_t                      state_d;
   logic [SLOTW-1:0]            slot_q;
   logic [SLOTW-1:0]            slot_d;
   logic [CHANNELS*WIDTH-1:0]   dataout_q;
   logic [CHANNELS*WIDTH-1:0]   dataout_d;
   logic                        frame_valid_q;
   logic                        frame_valid_d;
   logic                        sync_err_q;
   logic                        sync_err_d;

   logic                        stage_we;
   logic [SLOTW-1:0]            stage_idx;
   logic [WIDTH-1:0]            staging_q [CHANNELS-1];
   logic [CHANNELS*WIDTH-1:0]   frame_word;

   // The slot CHANNELS-1 word is never staged: it is merged directly with the
   // staged slots 0..CHANNELS-2 so the completed frame can be published on the
   // same edge that accepts its last word.
   always_comb begin
      frame_word = '0;
      for (int k = 0; k < CHANNELS - 1; k++) begin
         frame_word[k*WIDTH +: WIDTH] = staging_q[k];
      end
      frame_word[(CHANNELS-1)*WIDTH +: WIDTH] = datain;
   end

   // Next-state logic. Nothing moves unless a word is accepted. A sync seen
   // away from slot 0 while locked means we drifted out of alignment: the
   // partial frame is dropped and the word restarts a frame as slot 0, so we
   // stay locked and realign in one step instead of going back to hunting.
   // The sync-error branch is checked before frame completion, which keeps
   // frame_valid and sync_err mutually exclusive.
   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      dataout_d     = dataout_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      stage_we      = 1'b0;
      stage_idx     = slot_q;

      if (valid_in) begin
         unique case (state_q)
            HUNT: begin
               if (sync) begin
                  stage_we  = 1'b1;
                  stage_idx = '0;
                  slot_d    = FIRST_NEXT;
                  state_d   = LOCKED;
               end
            end

            LOCKED: begin
               if (sync && (slot_q != '0)) begin
                  sync_err_d = 1'b1;
                  stage_we   = 1'b1;
                  stage_idx  = '0;
                  slot_d     = FIRST_NEXT;
               end else if (slot_q == LAST_SLOT) begin
                  dataout_d     = frame_word;
                  frame_valid_d = 1'b1;
                  slot_d        = '0;
               end else begin
                  stage_we  = 1'b1;
                  stage_idx = slot_q;
                  slot_d    = slot_q + FIRST_NEXT;
               end
            end

            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // Control and output registers. Reset is asynchronous so a mid-frame reset
   // drops the block back to hunting and clears the visible frame at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= '0;
         dataout_q     <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         dataout_q     <= dataout_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   // Staging registers for slots 0..CHANNELS-2. Only the addressed entry is
   // written; stale entries from an abandoned frame are simply overwritten as
   // the new frame fills in, since they are never published before that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CHANNELS - 1; k++) begin
            staging_q[k] <= '0;
         end
      end else if (stage_we) begin
         for (int k = 0; k < CHANNELS - 1; k++) begin
            if (stage_idx == SLOTW'(k)) begin
               staging_q[k] <= datain;
            end
         end
      end
   end

   // Every output comes straight from a flop.
   always_comb begin
      dataout     = dataout_q;
      frame_valid = frame_valid_q;
      sync_err    = sync_err_q;
      slot        = slot_q;
      locked      = (state_q == LOCKED);
   end

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//
// Directed testbench for tdm_demux with WIDTH=8, CHANNELS=4. A table of
// hand-computed vectors covers framing, hunting, gaps and realignment; the
// reset scenarios are written out by hand because they depend on rst_n
// moving between clock edges.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;

   logic                      clk;
   logic                      rst_n;
   logic [WIDTH-1:0]          datain;
   logic                      valid_in;
   logic                      sync;
   logic [CHANNELS*WIDTH-1:0] dataout;
   logic                      frame_valid;
   logic                      locked;
   logic [1:0]                slot;
   logic                      sync_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic [31:0] edo;
      logic        efv;
      logic        elk;
      logic [1:0]  esl;
      logic        ese;
   } vec_t;

   vec_t vecs[$];

   tdm_demux #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .datain      (datain),
      .valid_in    (valid_in),
      .sync        (sync),
      .dataout     (dataout),
      .frame_valid (frame_valid),
      .locked      (locked),
      .slot        (slot),
      .sync_err    (sync_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic addVec(input logic rst, input logic v, input logic s,
                         input logic [7:0] d, input logic [31:0] edo,
                         input logic efv, input logic elk,
                         input logic [1:0] esl, input logic ese);
      vec_t x;
      x.rst = rst; x.v = v; x.s = s; x.d = d; x.edo = edo;
      x.efv = efv; x.elk = elk; x.esl = esl; x.ese = ese;
      vecs.push_back(x);
   endtask

   // Drive at the falling edge, then step past the rising edge so outputs
   // are sampled well away from the active edge.
   task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      valid_in = v;
      sync     = s;
      datain   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] edo,
                              input logic efv, input logic elk,
                              input logic [1:0] esl, input logic ese);
      checks++;
      if (dataout !== edo) begin
         errors++;
         $display("[TB] FAIL %s dataout: got %h expected %h", name, dataout, edo);
      end
      checks++;
      if (frame_valid !== efv) begin
         errors++;
         $display("[TB] FAIL %s frame_valid: got %b expected %b", name, frame_valid, efv);
      end
      checks++;
      if (locked !== elk) begin
         errors++;
         $display("[TB] FAIL %s locked: got %b expected %b", name, locked, elk);
      end
      checks++;
      if (slot !== esl) begin
         errors++;
         $display("[TB] FAIL %s slot: got %0d expected %0d", name, slot, esl);
      end
      checks++;
      if (sync_err !== ese) begin
         errors++;
         $display("[TB] FAIL %s sync_err: got %b expected %b", name, sync_err, ese);
      end
   endtask

   initial begin
      // ---- vector table ---------------------------------------------------
      // basic frame straight out of reset
      addVec(1, 1, 1, 8'h11, 32'h0,        0, 1, 1, 0);
      addVec(0, 1, 0, 8'h22, 32'h0,        0, 1, 2, 0);
      addVec(0, 1, 0, 8'h33, 32'h0,        0, 1, 3, 0);
      addVec(0, 1, 0, 8'h44, 32'h44332211, 1, 1, 0, 0);
      // hunt discard
      addVec(1, 1, 0, 8'hAA, 32'h0,        0, 0, 0, 0);
      addVec(0, 1, 0, 8'hBB, 32'h0,        0, 0, 0, 0);
      addVec(0, 1, 1, 8'h01, 32'h0,        0, 1, 1, 0);
      addVec(0, 1, 0, 8'h02, 32'h0,        0, 1, 2, 0);
      addVec(0, 1, 0, 8'h03, 32'h0,        0, 1, 3, 0);
      addVec(0, 1, 0, 8'h04, 32'h04030201, 1, 1, 0, 0);
      // gaps of three idle cycles, idle cycles carry junk incl. sync=1
      addVec(1, 1, 1, 8'h01, 32'h0,        0, 1, 1, 0);
      addVec(0, 0, 1, 8'hFF, 32'h0,        0, 1, 1, 0);
      addVec(0, 0, 0, 8'hEE, 32'h0,        0, 1, 1, 0);
      addVec(0, 0, 1, 8'hDD, 32'h0,        0, 1, 1, 0);
      addVec(0, 1, 0, 8'h02, 32'h0,        0, 1, 2, 0);
      addVec(0, 0, 1, 8'hFF, 32'h0,        0, 1, 2, 0);
      addVec(0, 0, 0, 8'hEE, 32'h0,        0, 1, 2, 0);
      addVec(0, 0, 1, 8'hDD, 32'h0,        0, 1, 2, 0);
      addVec(0, 1, 0, 8'h03, 32'h0,        0, 1, 3, 0);
      addVec(0, 0, 1, 8'hFF, 32'h0,        0, 1, 3, 0);
      addVec(0, 0, 0, 8'hEE, 32'h0,        0, 1, 3, 0);
      addVec(0, 0, 1, 8'hDD, 32'h0,        0, 1, 3, 0);
      addVec(0, 1, 0, 8'h04, 32'h04030201, 1, 1, 0, 0);
      addVec(0, 0, 0, 8'h55, 32'h04030201, 0, 1, 0, 0);
      // misalignment at slot 2
      addVec(0, 1, 1, 8'h10, 32'h04030201, 0, 1, 1, 0);
      addVec(0, 1, 0, 8'h20, 32'h04030201, 0, 1, 2, 0);
      addVec(0, 1, 1, 8'h30, 32'h04030201, 0, 1, 1, 1);
      addVec(0, 1, 0, 8'h40, 32'h04030201, 0, 1, 2, 0);
      addVec(0, 1, 0, 8'h50, 32'h04030201, 0, 1, 3, 0);
      addVec(0, 1, 0, 8'h60, 32'h60504030, 1, 1, 0, 0);
      // misalignment at the last slot: the frame must not complete
      addVec(0, 1, 1, 8'hA1, 32'h60504030, 0, 1, 1, 0);
      addVec(0, 1, 0, 8'hA2, 32'h60504030, 0, 1, 2, 0);
      addVec(0, 1, 0, 8'hA3, 32'h60504030, 0, 1, 3, 0);
      addVec(0, 1, 1, 8'hB0, 32'h60504030, 0, 1, 1, 1);
      addVec(0, 1, 0, 8'hB1, 32'h60504030, 0, 1, 2, 0);
      addVec(0, 1, 0, 8'hB2, 32'h60504030, 0, 1, 3, 0);
      addVec(0, 1, 0, 8'hB3, 32'hB3B2B1B0, 1, 1, 0, 0);
      // back-to-back frame with no sync once locked
      addVec(0, 1, 0, 8'hC0, 32'hB3B2B1B0, 0, 1, 1, 0);
      addVec(0, 1, 0, 8'hC1, 32'hB3B2B1B0, 0, 1, 2, 0);
      addVec(0, 1, 0, 8'hC2, 32'hB3B2B1B0, 0, 1, 3, 0);
      addVec(0, 1, 0, 8'hC3, 32'hC3C2C1C0, 1, 1, 0, 0);

      // ---- reset held with random inputs ----------------------------------
      rst_n    = 1'b0;
      valid_in = 1'b0;
      sync     = 1'b0;
      datain   = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         valid_in = 1'($urandom_range(0, 1));
         sync     = 1'($urandom_range(0, 1));
         datain   = 8'($urandom);
         @(posedge clk);
         #1;
         checkOutput($sformatf("reset_hold%0d", i), 32'h0, 0, 0, 2'd0, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 1, 8'h5A);
      checkOutput("reset_release_lock", 32'h0, 0, 1, 2'd1, 0);

      // ---- table-driven vectors -------------------------------------------
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) pulseReset();
         valid_in = vecs[i].v;
         sync     = vecs[i].s;
         datain   = vecs[i].d;
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].edo, vecs[i].efv,
                     vecs[i].elk, vecs[i].esl, vecs[i].ese);
      end

      // ---- mid-frame asynchronous reset -----------------------------------
      pulseReset();
      applyStimulus(1, 1, 8'h11);
      applyStimulus(1, 0, 8'h22);
      applyStimulus(1, 0, 8'h33);
      applyStimulus(1, 0, 8'h44);
      checkOutput("midreset_frame", 32'h44332211, 1, 1, 2'd0, 0);
      applyStimulus(1, 1, 8'h55);
      applyStimulus(1, 0, 8'h66);
      checkOutput("midreset_partial", 32'h44332211, 0, 1, 2'd2, 0);
      @(negedge clk);
      valid_in = 1'b1;
      sync     = 1'b0;
      datain   = 8'h77;
      rst_n    = 1'b0;
      #1;
      checkOutput("midreset_async", 32'h0, 0, 0, 2'd0, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_discard77", 32'h0, 0, 0, 2'd0, 0);
      applyStimulus(1, 0, 8'h88);
      checkOutput("midreset_discard88", 32'h0, 0, 0, 2'd0, 0);
      applyStimulus(1, 1, 8'h99);
      checkOutput("midreset_relock", 32'h0, 0, 1, 2'd1, 0);
      applyStimulus(1, 0, 8'h9A);
      applyStimulus(1, 0, 8'h9B);
      applyStimulus(1, 0, 8'h9C);
      checkOutput("midreset_newframe", 32'h9C9B9A99, 1, 1, 2'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
